// File: rtl/siso_pkg.sv
// Framing definitions shared by the serializer and the downstream deserializer,
// so both ends of the SISO chain agree on bit order, levels and frame length.
package siso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    DATA   = 2'd2,
    PARITY = 2'd3
  } state_t;

  localparam logic IDLE_LEVEL  = 1'b0;
  localparam logic START_LEVEL = 1'b1;

  function automatic int frame_len(input int width, input bit start_en, input bit parity_en);
    return int'(start_en) + width + int'(parity_en);
  endfunction

endpackage

// File: rtl/piso_frame_serializer.sv
// Parallel-in serial-out framer: accepts a word on valid/ready and emits
// [start] data [parity] on serial_out, one bit per clock, idling low.
module piso_frame_serializer
  import siso_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit START_EN   = 1'b1,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] par_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(WIDTH - 2);

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CNT_W-1:0] cnt;
  logic             par_bit;
  logic             accept;

  function automatic logic head_bit(input logic [WIDTH-1:0] x);
    return MSB_FIRST ? x[WIDTH-1] : x[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] x);
    return MSB_FIRST ? {x[WIDTH-2:0], 1'b0} : {1'b0, x[WIDTH-1:1]};
  endfunction

  function automatic logic parity_of(input logic [WIDTH-1:0] x);
    return (^x) ^ PARITY_ODD;
  endfunction

  // in_ready is registered, so accept never depends combinationally on itself
  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      serial_out <= IDLE_LEVEL;
      busy       <= 1'b0;
      done       <= 1'b0;
      in_ready   <= 1'b1;
      cnt        <= '0;
    end else if (accept) begin
      par_bit  <= parity_of(par_in);
      busy     <= 1'b1;
      done     <= 1'b0;
      in_ready <= 1'b0;
      if (START_EN) begin
        state      <= START;
        serial_out <= START_LEVEL;
        sreg       <= par_in;
      end else begin
        state      <= DATA;
        cnt        <= '0;
        serial_out <= head_bit(par_in);
        sreg       <= shift_out(par_in);
      end
    end else begin
      case (state)
        IDLE: begin
          serial_out <= IDLE_LEVEL;
          busy       <= 1'b0;
          done       <= 1'b0;
          in_ready   <= 1'b1;
        end
        START: begin
          state      <= DATA;
          cnt        <= '0;
          serial_out <= head_bit(sreg);
          sreg       <= shift_out(sreg);
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            if (PARITY_EN) begin
              state      <= PARITY;
              serial_out <= par_bit;
              done       <= 1'b1;
              in_ready   <= 1'b1;
            end else begin
              state      <= IDLE;
              serial_out <= IDLE_LEVEL;
              busy       <= 1'b0;
              done       <= 1'b0;
              in_ready   <= 1'b1;
            end
          end else begin
            cnt        <= cnt + CNT_W'(1);
            serial_out <= head_bit(sreg);
            sreg       <= shift_out(sreg);
            // Outputs are registered, so flag the last data bit one step early
            if (!PARITY_EN && cnt == CNT_PENULT) begin
              done     <= 1'b1;
              in_ready <= 1'b1;
            end
          end
        end
        default: begin
          state      <= IDLE;
          serial_out <= IDLE_LEVEL;
          busy       <= 1'b0;
          done       <= 1'b0;
          in_ready   <= 1'b1;
        end
      endcase
    end
  end

endmodule
